// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-generic ALU with multi-cycle unsigned multiply/divide
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cf,
    output logic             ovf,
    output logic             z,
    output logic             neg
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_ADDS = 4'd2;
    localparam logic [3:0] OP_SUBS = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             cf_q, cf_d, ovf_q, ovf_d, z_q, z_d, neg_q, neg_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sll_w, srl_w, sra_w;
    logic [WIDTH-1:0] sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_ovf;

    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign in_ready = (state_q == ST_IDLE) && !areset;
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];

    // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = a - b;
    assign sll_w = {1'b0, a} << shamt;
    assign srl_w = {a, 1'b0} >> shamt;
    assign sra_w = $unsigned($signed({a, 1'b0}) >>> shamt);

    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADDU: begin alu_res = add_w[WIDTH-1:0]; alu_cf = add_w[WIDTH]; end
            OP_SUBU: begin alu_res = sub_w; alu_cf = (a >= b); end
            OP_ADDS: begin
                alu_res = add_w[WIDTH-1:0];
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBS: begin
                alu_res = sub_w;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  begin alu_res = sll_w[WIDTH-1:0]; alu_cf = sll_w[WIDTH]; end
            OP_SRL:  begin alu_res = srl_w[WIDTH:1];   alu_cf = srl_w[0];     end
            OP_SRA:  begin alu_res = sra_w[WIDTH:1];   alu_cf = sra_w[0];     end
            default: ;
        endcase
    end

    // Multiply: {hi,lo} shift right with conditional add of a. Divide: restoring,
    // dividend shifts out of lo into hi while quotient bits shift into lo.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    always_comb begin
        if (is_div_q) begin
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        cf_d        = cf_q;
        ovf_d       = ovf_q;
        z_d         = z_q;
        neg_d       = neg_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MULU || op == OP_DIVU) begin
                        state_d  = ST_BUSY;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (op == OP_DIVU);
                        opnd_d   = (op == OP_DIVU) ? b : a;
                        lo_d     = (op == OP_DIVU) ? a : b;
                        hi_d     = '0;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        cf_d        = alu_cf;
                        ovf_d       = alu_ovf;
                        z_d         = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_IDLE;
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    cf_d        = is_div_q ? 1'b0 : (step_hi != '0);
                    ovf_d       = is_div_q ? (opnd_q == '0) : (step_hi != '0);
                    z_d         = (step_lo == '0);
                    neg_d       = step_lo[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            cf_q        <= 1'b0;
            ovf_q       <= 1'b0;
            z_q         <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            cf_q        <= cf_d;
            ovf_q       <= ovf_d;
            z_q         <= z_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cf        = cf_q;
    assign ovf       = ovf_q;
    assign z         = z_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic model
module tb_alu_seq;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         areset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic [W-1:0] result, result_hi;
    logic         cf, ovf, z, neg;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
        .result_hi(result_hi), .cf(cf), .ovf(ovf), .z(z), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic on plain integers, signed views by subtracting M.
    task automatic model(input int o, input int x, input int y,
                         output int r, output int rh, output int c, output int v);
        int sx, sy, s, n;
        r = 0; rh = 0; c = 0; v = 0;
        sx = (x >= M/2) ? x - M : x;
        sy = (y >= M/2) ? y - M : y;
        n  = y % W;
        case (o)
            0: begin s = x + y; r = s % M; c = (s >= M); end
            1: begin r = (x - y + M) % M; c = (x >= y); end
            2: begin s = sx + sy; r = (s + 2*M) % M; v = (s > M/2 - 1 || s < -M/2); end
            3: begin s = sx - sy; r = (s + 2*M) % M; v = (s > M/2 - 1 || s < -M/2); end
            4: r = x & y;
            5: r = x | y;
            6: r = x ^ y;
            7: begin r = (x * (1 << n)) % M; c = (n > 0) ? (x >> (W - n)) & 1 : 0; end
            8: begin r = x >> n; c = (n > 0) ? (x >> (n - 1)) & 1 : 0; end
            9: begin r = (sx >>> n) & (M - 1); c = (n > 0) ? (x >> (n - 1)) & 1 : 0; end
            10: begin s = x * y; r = s % M; rh = s / M; c = (rh != 0); v = c; end
            11: begin
                if (y == 0) begin r = M - 1; rh = x; v = 1; end
                else begin r = x / y; rh = x % y; end
            end
            default: ;
        endcase
    endtask

    task automatic check_outs(input string tag, input int o, input int x, input int y);
        int r, rh, c, v;
        model(o, x, y, r, rh, c, v);
        check($sformatf("%s res op%0d a=%0d b=%0d", tag, o, x, y), result, r);
        check($sformatf("%s hi op%0d", tag, o), result_hi, rh);
        check($sformatf("%s cf/ovf op%0d", tag, o), {cf, ovf}, {c[0], v[0]});
        check($sformatf("%s z/neg op%0d", tag, o), {z, neg}, {r == 0, r >= M/2});
    endtask

    // Issue one op from a negedge, wait for its pulse, check it and that it holds.
    task automatic run_op(input int o, input int x, input int y);
        int lat, low;
        in_valid = 1'b1; op = 4'(o); a = W'(x); b = W'(y);
        check("ready before accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        if (o == 10 || o == 11) begin
            lat = 1; low = 0;
            for (int k = 0; k < 40; k++) begin
                if (!in_ready) low++;
                if (out_valid) break;
                @(negedge clk);
                lat++;
            end
            check($sformatf("latency op%0d", o), lat, W + 1);
            check($sformatf("ready low op%0d", o), low, W);
        end else begin
            check($sformatf("pulse op%0d", o), out_valid, 1);
        end
        check_outs("op", o, x, y);
        @(negedge clk);
        check("pulse ends", out_valid, 0);
        check_outs("hold", o, x, y);
    endtask

    initial begin
        int cnt;
        areset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("ready in reset", in_ready, 0);
        areset = 1'b0;
        #1;
        check("ready after reset", in_ready, 1);
        check("reset outs", {out_valid, result, result_hi, cf, ovf, z, neg}, 0);
        @(negedge clk);

        run_op(10, 200, 3);
        check("mulu const", {result_hi, result, cf, ovf, z}, {8'h02, 8'h58, 3'b110});
        run_op(11, 100, 7);
        run_op(11, 8'h55, 0);
        check("divu0 const", {result, result_hi, ovf, neg}, {8'hFF, 8'h55, 2'b11});
        run_op(2, 8'h7F, 8'h01);
        run_op(0, 8'hFF, 8'h01);
        run_op(1, 5, 5);
        run_op(7, 8'h81, 1);
        run_op(9, 8'h80, 3);
        check("sra const", result, 8'hF0);
        run_op(8, 8'h01, 0);
        run_op(7, 8'h81, 8'h09);
        check("sll b[2:0] const", {result, cf}, {8'h02, 1'b1});
        run_op(3, 8'h80, 8'h01);

        // Back-to-back single-cycle ops with in_valid held high.
        in_valid = 1'b1; op = 4'd0; a = 8'd40; b = 8'd2;
        @(posedge clk); @(negedge clk);
        check("b2b pulse 1", out_valid, 1);
        check_outs("b2b1", 0, 40, 2);
        op = 4'd6; a = 8'hA5; b = 8'h0F;
        @(posedge clk); @(negedge clk);
        check("b2b pulse 2", out_valid, 1);
        check_outs("b2b2", 6, 8'hA5, 8'h0F);
        op = 4'd13; a = 8'h12; b = 8'h34;
        @(posedge clk); @(negedge clk);
        check("b2b pulse 3", out_valid, 1);
        check_outs("b2b3", 13, 8'h12, 8'h34);
        in_valid = 1'b0;
        @(negedge clk);

        // Reset four iterations into a multiply aborts it.
        run_op(0, 7, 9);
        in_valid = 1'b1; op = 4'd10; a = 8'd77; b = 8'd99;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check("abort outs", {out_valid, result, result_hi, cf, ovf, z, neg}, 0);
        check("abort ready in reset", in_ready, 0);
        areset = 1'b0;
        #1;
        check("abort ready after", in_ready, 1);
        cnt = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("abort no pulse", cnt, 0);
        run_op(0, 2, 3);

        // An op presented on a reset edge is dropped.
        in_valid = 1'b1; op = 4'd0; a = 8'd1; b = 8'd1; areset = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; areset = 1'b0;
        @(negedge clk);
        check("reset-edge drop", {out_valid, result}, 0);

        for (int i = 0; i < 250; i++)
            run_op($urandom_range(0, 15), $urandom_range(0, M - 1),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the mini-CPU execute stage; the next-generation replacement for the 8-bit combinational ALU. It adds WIDTH-generic datapath, barrel shifts, and multi-cycle unsigned multiply/divide, using a valid/ready handshake so the control unit can stall on long operations. All results and flags are registered and held until the next completion.

## Interface
- WIDTH, 8: operand/result width, ≥4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

- clk  in  1  rising-edge clock
- areset  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept; accept = in_valid && in_ready at an edge
- op  in  4  opcode: 0 ADDU, 1 SUBU, 2 ADDS, 3 SUBS, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MULU, 11 DIVU, 12-15 reserved
- a, b  in  WIDTH  operands; captured at accept, ignored otherwise
- out_valid  out  1  one-cycle pulse: result/flags just updated
- result  out  WIDTH  low result / product low / quotient
- result_hi  out  WIDTH  product high / remainder; 0 for other ops
- cf, ovf, z, neg  out  1 each  carry, signed overflow, zero, negative

## Operation
- States: IDLE, BUSY. in_ready = (state==IDLE) && !areset.
- IDLE, accept of single-cycle op (0-9, 12-15): result and flags registered at the accept edge; out_valid=1 next cycle; stay IDLE.
- IDLE, accept of MULU/DIVU: load operands and counter=WIDTH, go BUSY. One shift-add (MULU) or restoring-subtract (DIVU) iteration per edge; result, result_hi, flags registered on the edge where counter reaches 0, then go IDLE.
- Outputs hold their values between out_valid pulses; unaccepted cycles change nothing.
- Arithmetic, all mod 2^WIDTH, cf/ovf default 0:
  - ADDU: cf = carry out of WIDTH-bit add.
  - SUBU: cf = (a >= b) unsigned, i.e. no borrow.
  - ADDS: ovf = a,b same sign and result sign differs.
  - SUBS: ovf = a,b different sign and result sign differs from a.
  - AND/OR/XOR: bitwise.
  - SLL/SRL/SRA: shift a by b[SHW-1:0]; cf = last bit shifted out, 0 if amount is 0. SRA replicates a[WIDTH-1].
  - MULU: {result_hi,result} = a*b unsigned; cf = ovf = (result_hi != 0).
  - DIVU: result = a/b, result_hi = a%b. b==0: result all-ones, result_hi = a, ovf = 1; still takes WIDTH iterations.
  - Reserved: result 0, result_hi 0, cf = ovf = 0.
- z = (result == 0), low word only; neg = result[WIDTH-1]; both registered with result.

## Timing
- Reset values: result 0, result_hi 0, cf/ovf/z/neg 0, out_valid 0, state IDLE, counter 0; in_ready 0 during reset, 1 on the first cycle after.
- Single-cycle latency: accept at edge T, out_valid high in cycle T..T+1. Throughput is 1 op/cycle; in_valid held high yields back-to-back pulses.
- MULU/DIVU latency: accept at edge T, result registered at edge T+WIDTH, out_valid high in the following cycle. in_ready is low from T to T+WIDTH. A new op may be accepted at edge T+WIDTH+1, coincident with the out_valid cycle.
- Reset mid-BUSY aborts the operation: no out_valid, outputs cleared, IDLE next cycle.
- Reset asserted on an accept edge: reset wins and the op is dropped.
- in_valid while BUSY is not accepted; the requester must hold it.

## Test plan
- WIDTH=8, MULU a=200, b=3 -> 8 edges after accept: result 0x58, result_hi 0x02, cf=ovf=1, z=0; in_ready low for exactly 8 cycles.
- DIVU 100/7 -> result 14, result_hi 2, ovf=0. DIVU 0x55/0 -> result 0xFF, result_hi 0x55, ovf=1, neg=1.
- ADDS 0x7F+0x01 -> result 0x80, ovf=1, neg=1, cf=0. ADDU 0xFF+0x01 -> result 0x00, cf=1, z=1. SUBU 5-5 -> result 0, cf=1, z=1.
- SLL 0x81 by 1 -> 0x02, cf=1. SRA 0x80 by 3 -> 0xF0, cf=0. SRL 0x01 by 0 -> 0x01, cf=0. Shift amount taken from b[2:0] only (b=0x09 shifts by 1).
- in_valid high for 3 cycles with ADDU, XOR, reserved op 13 -> 3 accepts, out_valid high for 3 consecutive cycles with matching results; op 13 gives result 0, z=1.
- Accept MULU, assert areset after 4 iterations -> no out_valid pulse, all outputs 0, in_ready=1 the cycle after reset deasserts; a following ADDU 2+3 returns 5.
